// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op_i codes and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit 1 of the opcode separates the divide family from the multiply family.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Bit 0 clear means the operands are interpreted as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// The divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_nxt
);

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // Divide: acc = {partial remainder, dividend/quotient}; shift left and trial-subtract.
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   div_nxt;

  always_comb begin
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (!diff[WIDTH])
      div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  assign acc_nxt = is_div ? div_nxt : mul_nxt;
`else
  assign acc_nxt = is_div ? {(2*WIDTH){1'b0}} : mul_nxt;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one result bit per cycle, WIDTH RUN cycles.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall_o
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               is_div_q;
  logic               neg_lo_q;
`ifdef MULDIV_DIV_EN
  logic               neg_hi_q;
`endif

  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    logic signed [WIDTH-1:0] s;
    s = v;
    return n ? -s : s;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    logic signed [2*WIDTH-1:0] s;
    s = v;
    return n ? -s : s;
  endfunction

  assign accept  = (state == ST_IDLE) && start_i && !flush_i;
  assign stall_o = start_i | (state == ST_RUN);

  always_comb begin
    a_neg = op_is_signed(op_i) & a_i[WIDTH-1];
    b_neg = op_is_signed(op_i) & b_i[WIDTH-1];
    a_abs = neg_w(a_i, a_neg);
    b_abs = neg_w(b_i, b_neg);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  // Sign fix-up is applied to the final iteration's output as it is committed.
  always_comb begin
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      res_hi = neg_w(acc_nxt[2*WIDTH-1:WIDTH], neg_hi_q);
      res_lo = neg_w(acc_nxt[WIDTH-1:0], neg_lo_q);
    end else begin
      {res_hi, res_lo} = neg_2w(acc_nxt, neg_lo_q);
    end
`else
    {res_hi, res_lo} = neg_2w(acc_nxt, neg_lo_q);
`endif
  end

  // Operand/accumulator datapath: loaded on accept, stepped every RUN cycle.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      is_div_q <= op_is_div(op_i);
      acc      <= {{WIDTH{1'b0}}, (op_is_div(op_i) ? a_abs : b_abs)};
      opnd     <= op_is_div(op_i) ? b_abs : a_abs;
      // A zero divisor keeps the all-ones quotient unsigned.
      neg_lo_q <= op_is_div(op_i) ? ((a_neg ^ b_neg) & (|b_i)) : (a_neg ^ b_neg);
`ifdef MULDIV_DIV_EN
      neg_hi_q <= a_neg;
`endif
    end else if (state == ST_RUN) begin
      acc <= acc_nxt;
    end
  end

  // Control FSM with registered busy/done and committed result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state  <= ST_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              cnt    <= '0;
              busy_o <= 1'b1;
`ifdef MULDIV_DIV_EN
              state  <= ST_RUN;
`else
              if (op_is_div(op_i)) begin
                state  <= ST_DONE;
                done_o <= 1'b1;
                hi_o   <= '0;
                lo_o   <= '0;
              end else begin
                state  <= ST_RUN;
              end
`endif
            end
          end
          ST_RUN: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              hi_o   <= res_hi;
              lo_o   <= res_lo;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): vector table plus flush/reset/back-to-back sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_o;

  int n_cmp = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .stall_o (stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one start pulse; returns one cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done_o && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int exp_lat;
    logic [31:0] ehi, elo;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{OP_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
    vecs[3]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4]  = '{OP_MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[5]  = '{OP_MULT,  32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};
    vecs[6]  = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[9]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[10] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[12] = '{OP_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};

    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    repeat (2) tick();
    chk("rst_hi", 64'(hi_o), 64'h0);
    chk("rst_lo", 64'(lo_o), 64'h0);
    chk("rst_done", 64'(done_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_stall", 64'(stall_o), 64'h0);
    #2 rst_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].op[1] && !DIV_EN) begin
        ehi = '0; elo = '0; exp_lat = 1;
      end else begin
        ehi = vecs[i].hi; elo = vecs[i].lo; exp_lat = 33;
      end
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(exp_lat));
      chk($sformatf("v%0d_hi", i), 64'(hi_o), 64'(ehi));
      chk($sformatf("v%0d_lo", i), 64'(lo_o), 64'(elo));
      tick();
      chk($sformatf("v%0d_pulse", i), 64'({done_o, busy_o}), 64'h0);
    end

    // Back-to-back: second start held high through the first operation.
    op_i = OP_MULTU; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1;
    tick();
    a_i = 32'd5; b_i = 32'd6;
    wait_done(1, lat);
    chk("b2b1_lat", 64'(lat), 64'd33);
    chk("b2b1_lo", 64'({hi_o, lo_o}), 64'd12);
    tick();
    chk("b2b_idle", 64'({busy_o, stall_o}), 64'b01);
    tick();
    start_i = 1'b0;
    chk("b2b2_busy", 64'(busy_o), 64'h1);
    wait_done(1, lat);
    chk("b2b2_lat", 64'(lat), 64'd33);
    chk("b2b2_res", 64'({hi_o, lo_o}), 64'd30);
    tick();

    // start_i in RUN with other operands is ignored.
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    repeat (4) tick();
    op_i = OP_MULTU; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(6, lat);
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_res", 64'({hi_o, lo_o}), 64'hFFFFFFFF_FFFFFFEB);
    tick();
    tick();
    chk("ign_idle", 64'({busy_o, done_o}), 64'h0);

    // Flush at RUN cycle 10: no done, outputs held, restart right away.
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_busy", 64'({busy_o, done_o}), 64'h0);
    chk("fl_hold", 64'({hi_o, lo_o}), 64'hFFFFFFFF_FFFFFFEB);
    issue(OP_MULTU, 32'd5, 32'd6);
    wait_done(1, lat);
    chk("fl_lat", 64'(lat), 64'd33);
    chk("fl_res", 64'({hi_o, lo_o}), 64'd30);
    tick();

    // flush_i together with start_i: not accepted.
    op_i = OP_MULTU; a_i = 32'd2; b_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    chk("fs_busy", 64'(busy_o), 64'h0);
    repeat (40) tick();
    chk("fs_hold", 64'({hi_o, lo_o, done_o}), {31'd0, 32'd30, 1'b0});

    // Asynchronous reset mid-RUN, then immediate restart.
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (7) tick();
    #3 rst_i = 1'b1;
    #1;
    chk("mrst_res", 64'({hi_o, lo_o}), 64'h0);
    chk("mrst_ctl", 64'({busy_o, done_o}), 64'h0);
    #1 rst_i = 1'b0;
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(1, lat);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_res", 64'({hi_o, lo_o}), 64'd12);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result-half width (even, >= 8).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, the reset; it SHALL be asynchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1, which requests an operation; it is sampled only in IDLE.
REQ-006 The block SHALL have port op_i, input, 2, selecting the operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 The block SHALL have ports a_i and b_i, input, WIDTH each, carrying the operands (rs, rt); they are sampled only with start_i.
REQ-008 The block SHALL have port flush_i, input, 1, which cancels the operation in flight.
REQ-009 The block SHALL have port busy_o, output, 1, asserted in RUN and DONE.
REQ-010 The block SHALL have port done_o, output, 1, a single-cycle pulse marking a valid result.
REQ-011 The block SHALL have ports hi_o and lo_o, output, WIDTH each, carrying the result (product high/low half, or remainder/quotient).
REQ-012 The block SHALL have port stall_o, output, 1, combinational: start_i | (state==RUN).

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 The FSM SHALL make these transitions:
- IDLE -> RUN on start_i & ~flush_i.
- RUN -> DONE after exactly WIDTH iterations.
- DONE -> IDLE unconditionally.
REQ-015 Accepting start_i SHALL latch op_i, |a_i| and |b_i| (absolute value for MULT and DIV, raw for the U ops) and the result signs, and SHALL clear the counter.
REQ-016 Multiply SHALL be radix-2 shift-add: one multiplier bit per RUN cycle into a 2*WIDTH accumulator.
REQ-017 Divide SHALL be restoring: one quotient bit per RUN cycle.
REQ-018 For MULT the product SHALL be negated when a_i[MSB]^b_i[MSB].
REQ-019 For DIV the quotient sign SHALL be a^b and the remainder sign SHALL be that of a.
REQ-020 DIV of the most negative value by -1 SHALL give quotient = most negative value and remainder = 0.
REQ-021 Divide by zero SHALL give lo_o = all ones and hi_o = a_i, with the normal latency and no exception.
REQ-022 hi_o/lo_o SHALL be registered and SHALL update only on entry to DONE; they SHALL otherwise hold the previous result.
REQ-023 Latency from the start_i accept edge to done_o high SHALL be WIDTH+1 cycles; done_o SHALL be high for exactly one cycle (DONE).
REQ-024 start_i in RUN or DONE SHALL be ignored, with no effect on the operation.
REQ-025 flush_i in any state SHALL force IDLE on the next edge and suppress done_o; hi_o/lo_o SHALL keep their old values.
REQ-026 flush_i together with start_i SHALL win: the operation is not accepted.
REQ-027 flush_i in the DONE cycle SHALL still let that cycle's done_o and result stand, since the result is already committed.

Reset
REQ-028 While rst_i is high the block SHALL hold: state=IDLE, counter=0, hi_o=0, lo_o=0, done_o=0, busy_o=0.
REQ-029 rst_i asserted mid-operation SHALL abort immediately with no done_o.
REQ-030 After rst_i deasserts, the first start_i SHALL be accepted on the next edge.

Configuration
REQ-031 With macro MULDIV_DIV_EN defined, DIV/DIVU SHALL be implemented as above.
REQ-032 With MULDIV_DIV_EN undefined, the divider datapath SHALL be absent; DIV/DIVU SHALL go IDLE -> DONE directly, with done_o 1 cycle after accept and hi_o=lo_o=0. MULT/MULTU SHALL be unchanged.

Structure
REQ-033 Package muldiv_pkg SHALL hold the op_i encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state enum.
REQ-034 The datapath step SHALL be one sub-module, muldiv_step (one add/sub-and-shift iteration, combinational), instantiated once.
REQ-035 The FSM, counter, sign fix-up and output registers SHALL be in muldiv_unit.

Verification
REQ-036 The bench SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done_o at cycle 33 after accept, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 The bench SHALL cover: MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-038 The bench SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 The bench SHALL cover: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, latency 33.
REQ-040 The bench SHALL cover: start MULTU 5*6, flush_i at RUN cycle 10 -> no done_o, hi/lo keep their previous values, a new start accepted on the next cycle gives 30.
REQ-041 The bench SHALL cover: start_i pulsed in RUN with other operands -> ignored, first result correct; rst_i pulsed mid-RUN -> outputs 0 immediately, busy_o=0; with MULTU 3*4 and MULTU 5*6 issued back-to-back (second start_i held through busy), both results correct in order.
